core_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the fetch/decode/execute datapath one instruction at a time. It drives the register-file write enable, instruction-register load and PC update. It runs req/ack handshakes with instruction and data memory, with a per-access timeout. It traps on illegal opcodes or bus timeouts and keeps a retired-instruction counter.

---
 rtl/core_sequencer_pkg.sv | 44 ++++
 rtl/core_sequencer_timeout_ctr.sv | 33 +++
 rtl/core_sequencer.sv | 145 ++++++++++++++
 tb/tb_core_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/core_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | core_sequencer_pkg: sequencer states, trap causes, RV32I opcodes   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM_TO = 2'd2,
    CAUSE_DMEM_TO = 2'd3
  } cause_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_OP, OP_OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_sequencer_timeout_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_timeout_ctr: per-access wait counter, expires at TIMEOUT-1     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module seq_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] c_last = W'(TIMEOUT - 1);

  logic [W-1:0] r_cnt;

  // Saturates at the last count so a held enable can never wrap past expiry.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_last)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_expired = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | core_sequencer: multi-cycle fetch/decode/execute control FSM       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module core_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_load,
  output logic             rf_we,
  output logic             pc_en,
  output logic             retire,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);
  import core_sequencer_pkg::*;

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_boundary;
  cause_t           r_cause;
  cause_t           w_cause_nxt;
  logic [CNT_W-1:0] r_instret;
  logic             w_expired;
  logic             w_wait_en;
  logic             w_wait_clr;

  assign w_wait_en  = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_wait_clr = !w_wait_en
                    || ((r_state == ST_FETCH) && imem_ack)
                    || ((r_state == ST_MEM) && dmem_ack);

  seq_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_wait_ctr (
    .clk       (clk),
    .rst       (reset),
    .i_clr     (w_wait_clr),
    .i_en      (w_wait_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cause   <= CAUSE_NONE;
      r_instret <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
      if (retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  // run is only consulted where an instruction retires.
  assign w_boundary = run ? ST_FETCH : ST_IDLE;

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    case (r_state)
      ST_IDLE:      if (run) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          w_state_nxt = ST_DECODE;
        end else if (w_expired) begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = CAUSE_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (is_legal_opcode(opcode)) begin
          w_state_nxt = ST_EXECUTE;
        end else begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = CAUSE_ILLEGAL;
        end
      end
      ST_EXECUTE: begin
        if (opcode == OP_BRANCH)         w_state_nxt = w_boundary;
        else if (mem_read || mem_write)  w_state_nxt = ST_MEM;
        else                             w_state_nxt = ST_WRITEBACK;
      end
      ST_MEM: begin
        if (dmem_ack) begin
          w_state_nxt = mem_read ? ST_WRITEBACK : w_boundary;
        end else if (w_expired) begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = CAUSE_DMEM_TO;
        end
      end
      ST_WRITEBACK: w_state_nxt = w_boundary;
      ST_TRAP:      w_state_nxt = ST_TRAP;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_load  = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      ST_EXECUTE:   retire = (opcode == OP_BRANCH);
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_write;
        retire   = dmem_ack && !mem_read;
      end
      ST_WRITEBACK: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_en      = retire;
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_TRAP);
  assign trap       = (r_state == ST_TRAP);
  assign trap_cause = r_cause;
  assign instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_core_sequencer: directed scoreboard bench for core_sequencer    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_core_sequencer;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  localparam logic [6:0] c_op_alu    = 7'b0110011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_bad    = 7'b1111111;

  logic             clk = 1'b0;
  logic             reset, run, mem_read, mem_write, imem_ack, dmem_ack;
  logic [6:0]       opcode;
  logic             imem_req, dmem_req, dmem_we, ir_load, rf_we, pc_en, retire, busy, trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  core_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .mem_read(mem_read), .mem_write(mem_write),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_load(ir_load), .rf_we(rf_we), .pc_en(pc_en), .retire(retire),
    .busy(busy), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  typedef struct {
    logic rf;
    int   lat;
    int   cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, cyc_n = 0, start_cyc = 0, retired = 0;
  logic prev_imem = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples outputs mid-cycle, retires scoreboard entries, then advances one clock.
  task automatic clk_step();
    exp_t e;
    @(negedge clk);
    if (imem_req && !prev_imem) start_cyc = cyc_n;
    prev_imem = imem_req;
    if (rf_we) check("rf_we_needs_pc_en", pc_en, 1'b1);
    if (pc_en) begin
      check("retire_with_pc_en", retire, 1'b1);
      check("retire_expected", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rf_we_at_retire", rf_we, e.rf);
        check("latency", cyc_n - start_cyc + 1, e.lat);
        check("instret_before_retire", instret, e.cnt);
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    clk_step();
    reset = 1'b0;
    sb.delete();
    retired = 0;
    check("rst_busy", busy, 1'b0);
    check("rst_trap", trap, 1'b0);
    check("rst_cause", trap_cause, 2'd0);
    check("rst_instret", instret, 0);
  endtask

  // One instruction from IDLE; run drops after the first cycle so it returns to IDLE.
  task automatic exec_one(input logic [6:0] opc, input logic mr, input logic mw,
                          input int i_wait, input int d_wait, input bit exp_ret,
                          input logic exp_rf, input int exp_lat,
                          output int ireq, output int dreq, output int dwe_bad);
    exp_t e;
    ireq = 0; dreq = 0; dwe_bad = 0;
    opcode = opc; mem_read = mr; mem_write = mw; run = 1'b1;
    if (exp_ret) begin
      e.rf = exp_rf; e.lat = exp_lat; e.cnt = retired;
      sb.push_back(e);
      retired++;
    end
    for (int k = 0; k < 80; k++) begin
      if (imem_req) ireq++;
      if (dmem_req) begin
        dreq++;
        if (dmem_we !== mw) dwe_bad++;
      end
      imem_ack = imem_req && (ireq > i_wait);
      dmem_ack = dmem_req && (dreq > d_wait);
      clk_step();
      if (k == 0) run = 1'b0;
      if (!busy) break;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    check("instr_settled", busy, 1'b0);
  endtask

  int ireq, dreq, dwe_bad, tcnt;

  initial begin
    reset = 1'b1; run = 1'b0; opcode = '0; mem_read = 1'b0; mem_write = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    clk_step();
    clk_step();
    check("reset_imem_req", imem_req, 1'b0);
    check("reset_dmem_req", dmem_req, 1'b0);
    check("reset_pc_en", pc_en, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_trap", trap, 1'b0);
    check("reset_cause", trap_cause, 2'd0);
    check("reset_instret", instret, 0);
    reset = 1'b0;
    clk_step();
    check("idle_without_run", busy, 1'b0);

    // ALU with zero-wait acks, then a delayed-ack load
    exec_one(c_op_alu, 1'b0, 1'b0, 0, 0, 1, 1'b1, 4, ireq, dreq, dwe_bad);
    check("alu_instret", instret, 1);
    exec_one(c_op_load, 1'b1, 1'b0, 0, 3, 1, 1'b1, 8, ireq, dreq, dwe_bad);
    check("load_dmem_req_cycles", dreq, 4);
    check("load_dmem_we_low", dwe_bad, 0);
    check("load_instret", instret, 2);

    // Store then branch after a fresh reset
    do_reset();
    exec_one(c_op_store, 1'b0, 1'b1, 0, 0, 1, 1'b0, 4, ireq, dreq, dwe_bad);
    check("store_dmem_req_cycles", dreq, 1);
    check("store_dmem_we_high", dwe_bad, 0);
    exec_one(c_op_branch, 1'b0, 1'b0, 0, 0, 1, 1'b0, 3, ireq, dreq, dwe_bad);
    check("branch_no_dmem", dreq, 0);
    check("store_branch_instret", instret, 2);
    exec_one(c_op_jal, 1'b0, 1'b0, 0, 0, 1, 1'b1, 4, ireq, dreq, dwe_bad);
    check("jal_instret", instret, 3);

    // Illegal opcode traps and sticks until reset
    do_reset();
    exec_one(c_op_bad, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, ireq, dreq, dwe_bad);
    check("illegal_trap", trap, 1'b1);
    check("illegal_cause", trap_cause, 2'd1);
    tcnt = 0;
    run = 1'b1;
    for (int k = 0; k < 20; k++) begin
      clk_step();
      if (trap && !busy && !imem_req) tcnt++;
    end
    check("trap_held_20", tcnt, 20);
    check("illegal_instret", instret, 0);
    do_reset();

    // Instruction-fetch timeout, then an ack on the last allowed cycle
    exec_one(c_op_alu, 1'b0, 1'b0, 1000, 0, 0, 1'b0, 0, ireq, dreq, dwe_bad);
    check("imem_to_req_cycles", ireq, TIMEOUT);
    check("imem_to_trap", trap, 1'b1);
    check("imem_to_cause", trap_cause, 2'd2);
    do_reset();
    exec_one(c_op_alu, 1'b0, 1'b0, TIMEOUT - 1, 0, 1, 1'b1, TIMEOUT + 3, ireq, dreq, dwe_bad);
    check("imem_late_req_cycles", ireq, TIMEOUT);
    check("imem_late_no_trap", trap, 1'b0);

    // Data-access timeout
    do_reset();
    exec_one(c_op_load, 1'b1, 1'b0, 0, 1000, 0, 1'b0, 0, ireq, dreq, dwe_bad);
    check("dmem_to_req_cycles", dreq, TIMEOUT);
    check("dmem_to_cause", trap_cause, 2'd3);

    // Reset during a pending data access
    do_reset();
    exec_one(c_op_alu, 1'b0, 1'b0, 0, 0, 1, 1'b1, 4, ireq, dreq, dwe_bad);
    opcode = c_op_load; mem_read = 1'b1; mem_write = 1'b0; run = 1'b1;
    imem_ack = 1'b1; dmem_ack = 1'b0;
    dreq = 0;
    for (int k = 0; k < 40 && dreq < 3; k++) begin
      clk_step();
      if (dmem_req) dreq++;
    end
    check("mem_wait_reached", dreq, 3);
    reset = 1'b1;
    clk_step();
    check("reset_mid_mem_dmem_req", dmem_req, 1'b0);
    check("reset_mid_mem_busy", busy, 1'b0);
    check("reset_mid_mem_instret", instret, 0);
    reset = 1'b0; run = 1'b0; imem_ack = 1'b0;
    sb.delete();
    clk_step();
    check("post_reset_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
